// File: rtl/alarm_trigger.sv
// alarm_trigger: keeps the running time-unit count and launches/holds the alarm
// (StartEq/AlarmOn) until the equation checker reports Correct or the user snoozes.
//   Clock, Reset          : clock and synchronous active-high reset
//   SetAlarm, AlarmIn     : pulse capturing the requested alarm time (clamped to MAX_TIME)
//   Snooze                : pulse postponing a ring by SNOOZE_UNITS, at most SNOOZE_MAX times
//   Correct               : level solve result from the checker
//   OngoingTimer          : current time unit, wraps MAX_TIME -> 0
//   StartEq, AlarmOn      : high for the whole ringing period
//   SnoozeCount           : snoozes used in the current ring
module alarm_trigger #(
   parameter int TICK_DIV     = 50000000,
   parameter int MAX_TIME     = 99,
   parameter int SNOOZE_UNITS = 5,
   parameter int SNOOZE_MAX   = 3
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       SetAlarm,
   input  logic [6:0] AlarmIn,
   input  logic       Snooze,
   input  logic       Correct,
   output logic [6:0] OngoingTimer,
   output logic       StartEq,
   output logic       AlarmOn,
   output logic [2:0] SnoozeCount
);
   localparam int DW = $clog2(TICK_DIV);
   typedef enum logic [2:0] {S_IDLE, S_ARMED, S_RINGING, S_SNOOZED, S_SOLVED} state_t;
   state_t        r_state, w_state_next;
   logic [DW-1:0] r_div_cnt;
   logic [6:0]    r_alarm_time, r_target, w_next_time, w_alarm_clamp, w_snooze_target;
   logic [7:0]    w_snooze_sum;
   logic          w_tick, w_hit, w_snooze_ok, w_ring_next;
   assign w_tick        = r_div_cnt == DW'(TICK_DIV - 1);
   assign w_next_time   = (OngoingTimer == 7'(MAX_TIME)) ? 7'd0 : OngoingTimer + 7'd1;
   // a ring fires only when time steps into the target, never when it already sits there
   assign w_hit         = w_tick && (w_next_time == r_target);
   assign w_alarm_clamp = (AlarmIn > 7'(MAX_TIME)) ? 7'(MAX_TIME) : AlarmIn;
   assign w_snooze_sum  = {1'b0, OngoingTimer} + 8'(SNOOZE_UNITS);
   assign w_snooze_target = 7'((w_snooze_sum > 8'(MAX_TIME)) ? w_snooze_sum - 8'(MAX_TIME + 1) : w_snooze_sum);
   assign w_snooze_ok   = Snooze && (SnoozeCount < 3'(SNOOZE_MAX));
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_div_cnt    <= '0;
         OngoingTimer <= '0;
      end else begin
         r_div_cnt    <= w_tick ? '0 : r_div_cnt + DW'(1);
         OngoingTimer <= w_tick ? w_next_time : OngoingTimer;
      end
   end
   always_ff @(posedge Clock) begin
      if (Reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end
   always_comb begin
      w_state_next = r_state;
      if (SetAlarm) w_state_next = S_ARMED;
      else begin
         case (r_state)
            S_ARMED, S_SNOOZED: w_state_next = w_hit ? S_RINGING : r_state;
            S_RINGING:          w_state_next = Correct ? S_SOLVED : (w_snooze_ok ? S_SNOOZED : S_RINGING);
            S_SOLVED:           w_state_next = Correct ? S_SOLVED : S_ARMED;
            default:            w_state_next = r_state;
         endcase
      end
   end
   // outputs are registered from the next state so a hit raises them on the same edge
   always_comb w_ring_next = (w_state_next == S_RINGING);
   always_ff @(posedge Clock) begin
      if (Reset) begin
         StartEq      <= 1'b0;
         AlarmOn      <= 1'b0;
         SnoozeCount  <= '0;
         r_alarm_time <= '0;
         r_target     <= '0;
      end else begin
         StartEq <= w_ring_next;
         AlarmOn <= w_ring_next;
         if (SetAlarm) begin
            r_alarm_time <= w_alarm_clamp;
            r_target     <= w_alarm_clamp;
            SnoozeCount  <= '0;
         end else if (r_state == S_RINGING && !Correct && w_snooze_ok) begin
            r_target    <= w_snooze_target;
            SnoozeCount <= SnoozeCount + 3'd1;
         end else if (r_state == S_SOLVED && !Correct) begin
            r_target    <= r_alarm_time;
            SnoozeCount <= '0;
         end
      end
   end
endmodule

// File: doc/alarm_trigger.md
# alarm_trigger

Upstream timekeeping and alarm-launch stage for the wake-up puzzle. It keeps the running time-unit count and drives it onto the equation checker's `OngoingTimer` input. When the count reaches the user-set alarm time, it raises `StartEq` and `AlarmOn`. It holds them until the checker reports `Correct` or the user snoozes, and it enforces a bounded snooze count.

## Interface
Parameters:
- `TICK_DIV`, default 50000000: Clock cycles per time unit. Must be ≥2.
- `MAX_TIME`, default 99: largest time value. The counter wraps MAX_TIME→0. Must be ≤127.
- `SNOOZE_UNITS`, default 5: time units added per snooze. Must be 1..MAX_TIME.
- `SNOOZE_MAX`, default 3: snoozes allowed per ring. Must be ≤7.

Ports:
- `Clock`, in, 1: system clock.
- `Reset`, in, 1: synchronous, active-high.
- `SetAlarm`, in, 1: single-cycle pulse; captures `AlarmIn`.
- `AlarmIn`, in, 7: requested alarm time.
- `Snooze`, in, 1: single-cycle pulse.
- `Correct`, in, 1: solve result from the equation checker. Level-sensitive.
- `OngoingTimer`, out, 7: current time unit, registered. Feeds the checker.
- `StartEq`, out, 1: launch/hold request to the checker, registered.
- `AlarmOn`, out, 1: buzzer/VGA alert, registered.
- `SnoozeCount`, out, 3: snoozes used in the current ring.

## Operation
Prescaler:
- `div_cnt` counts 0..TICK_DIV-1 and wraps.
- `tick` = (`div_cnt` == TICK_DIV-1), combinational.
- On each tick, `OngoingTimer` becomes (`OngoingTimer` == MAX_TIME) ? 0 : `OngoingTimer`+1.
- Time runs in all states.

Registers:
- `alarm_time`: the user setting.
- `target`: the next ring time.

Alarm capture (`SetAlarm`):
- In any state, sets `alarm_time` and `target` to min(`AlarmIn`, MAX_TIME).
- Clears `SnoozeCount`, moves to ARMED, and drops `StartEq`/`AlarmOn`.

"Hit" = a tick in which the incremented timer value equals `target`. A ring fires only on a transition *into* `target`; an alarm set equal to the current time waits one full wrap.

States:
- IDLE: StartEq=0, AlarmOn=0. Only `SetAlarm` leaves.
- ARMED: StartEq=0, AlarmOn=0.
  - hit → RINGING.
- RINGING: StartEq=1, AlarmOn=1.
  - `Correct`=1 → SOLVED.
  - else `Snooze`=1 and SnoozeCount<SNOOZE_MAX → SNOOZED. `target` ← (OngoingTimer + SNOOZE_UNITS) mod (MAX_TIME+1), computed on the value present that cycle. SnoozeCount+1.
  - `Snooze` with SnoozeCount==SNOOZE_MAX is ignored.
- SNOOZED: StartEq=0, AlarmOn=0.
  - hit → RINGING.
- SOLVED: StartEq=0, AlarmOn=0.
  - `Correct`=0 → ARMED, with `target` ← `alarm_time` and SnoozeCount ← 0. The alarm repeats next wrap.

Priority (same cycle), highest first:
1. Reset
2. SetAlarm
3. Correct
4. Snooze
5. hit

- `Correct` is ignored outside RINGING and SOLVED.
- `Correct` already high on entry to RINGING → SOLVED on the next edge.
- Modulo arithmetic is done at 8 bits, then truncated to 7.

## Timing
- Reset values: `div_cnt`=0, OngoingTimer=0, StartEq=0, AlarmOn=0, SnoozeCount=0, alarm_time=0, target=0, state=IDLE.
- Reset mid-ring drops all outputs on the next edge.
- Time units are TICK_DIV cycles apart. The first increment is at the edge after TICK_DIV cycles out of reset.
- A hit updates OngoingTimer, state, StartEq and AlarmOn on the same edge. No extra latency.
- Correct→StartEq low: 1 cycle.
- Snooze→StartEq low: 1 cycle.
- SetAlarm→ARMED/registers: 1 cycle.
- StartEq stays high for the whole RINGING period, so the checker can restart after a wrong answer without a re-launch.

## Test plan
Bench parameters: TICK_DIV=4, MAX_TIME=9, SNOOZE_UNITS=2, SNOOZE_MAX=2.

1. Reset, then run 40 cycles → OngoingTimer steps 0..9 every 4 cycles, then wraps to 0. All other outputs stay 0.
2. SetAlarm with AlarmIn=3 at time 0 → StartEq=AlarmOn=1 on the edge OngoingTimer becomes 3. Assert Correct 2 cycles later → StartEq=0 next edge, state SOLVED. Drop Correct → ARMED. Ring again at the next 3.
3. Ring at 3, Snooze → StartEq=0, SnoozeCount=1, target=5. Ring at 5, Snooze → target=7, count=2. Ring at 7, Snooze → ignored, StartEq stays 1.
4. Snooze while OngoingTimer=9 → target=1, ring on the wrap to 1.
5. AlarmIn=120 → target clamped to 9. SetAlarm equal to the current time (5) → no ring until the next 4→5 transition.
6. Corner cases:
   - Correct+Snooze in the same RINGING cycle → SOLVED, SnoozeCount unchanged.
   - SetAlarm+Correct in the same cycle → ARMED.
   - Reset asserted while RINGING → all outputs 0 next edge.
